// File: rtl/l2_refill_ctrl_if.sv
// L2 refill controller bus bundle: miss request, AXI-lite style memory
// channels, tag/data RAM refill port and requester completion.
interface l2_refill_ctrl_if;
    logic        miss_valid_i;
    logic        miss_ready_o;
    logic [31:0] miss_addr_i;
    logic        miss_is_i_i;
    logic        miss_we_i;
    logic [31:0] miss_wdat_i;
    logic [1:0]  miss_vld_i;
    logic [1:0]  miss_dirty_i;
    logic [15:0] miss_tag0_i;
    logic [15:0] miss_tag1_i;
    logic [31:0] miss_dat0_i;
    logic [31:0] miss_dat1_i;
    logic        hit_valid_i;
    logic [5:0]  hit_set_i;
    logic        hit_way_i;
    logic        arvalid_o;
    logic        arready_i;
    logic [31:0] araddr_o;
    logic        rvalid_i;
    logic        rready_o;
    logic [31:0] rdata_i;
    logic [1:0]  rresp_i;
    logic        awvalid_o;
    logic        awready_i;
    logic [31:0] awaddr_o;
    logic        wvalid_o;
    logic        wready_i;
    logic [31:0] wdata_o;
    logic        bvalid_i;
    logic        bready_o;
    logic [1:0]  bresp_i;
    logic [1:0]  refill_we_o;
    logic [5:0]  refill_set_o;
    logic [15:0] refill_tag_o;
    logic [31:0] refill_dat_o;
    logic        refill_dirty_o;
    logic        resp_valid_o;
    logic        resp_is_i_o;
    logic [31:0] resp_dat_o;
    logic        resp_err_o;
    logic        wb_err_o;

    modport slave (
        input  miss_valid_i, miss_addr_i, miss_is_i_i, miss_we_i,
        input  miss_wdat_i, miss_vld_i, miss_dirty_i,
        input  miss_tag0_i, miss_tag1_i, miss_dat0_i, miss_dat1_i,
        input  hit_valid_i, hit_set_i, hit_way_i,
        input  arready_i, rvalid_i, rdata_i, rresp_i,
        input  awready_i, wready_i, bvalid_i, bresp_i,
        output miss_ready_o, arvalid_o, araddr_o, rready_o,
        output awvalid_o, awaddr_o, wvalid_o, wdata_o, bready_o,
        output refill_we_o, refill_set_o, refill_tag_o,
        output refill_dat_o, refill_dirty_o,
        output resp_valid_o, resp_is_i_o, resp_dat_o, resp_err_o,
        output wb_err_o
    );

    modport master (
        output miss_valid_i, miss_addr_i, miss_is_i_i, miss_we_i,
        output miss_wdat_i, miss_vld_i, miss_dirty_i,
        output miss_tag0_i, miss_tag1_i, miss_dat0_i, miss_dat1_i,
        output hit_valid_i, hit_set_i, hit_way_i,
        output arready_i, rvalid_i, rdata_i, rresp_i,
        output awready_i, wready_i, bvalid_i, bresp_i,
        input  miss_ready_o, arvalid_o, araddr_o, rready_o,
        input  awvalid_o, awaddr_o, wvalid_o, wdata_o, bready_o,
        input  refill_we_o, refill_set_o, refill_tag_o,
        input  refill_dat_o, refill_dirty_o,
        input  resp_valid_o, resp_is_i_o, resp_dat_o, resp_err_o,
        input  wb_err_o
    );
endinterface

// File: rtl/l2_refill_ctrl.sv
// L2 miss/refill controller: 2-way, 64-set, one word per line, with
// dirty-victim writeback and per-set LRU tracking.
module l2_refill_ctrl (
    input  logic           clk,
    input  logic           rst_n,
    l2_refill_ctrl_if.slave bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WB     = 3'd1;
    localparam logic [2:0] B_WAIT = 3'd2;
    localparam logic [2:0] AR     = 3'd3;
    localparam logic [2:0] R_WAIT = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    logic [2:0]  state_q, state_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [5:0]  set_q;
    logic [15:0] tag_q;
    logic        is_i_q;
    logic        we_q;
    logic [31:0] wdat_q;
    logic        vic_q;
    logic [15:0] vtag_q;
    logic [31:0] vdat_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic [63:0] lru_q;
    logic        wb_err_q;

    logic [5:0]  in_set;
    logic        vic;
    logic        vic_dirty;
    logic        accept;
    logic        aw_fire;
    logic        w_fire;
    logic        done;
    logic        rd_err;
    logic [1:0]  refill_we;
    logic [31:0] out_dat;

    assign in_set = bus.miss_addr_i[7:2];
    assign accept = bus.miss_valid_i & (state_q == IDLE);

    // Lowest invalid way first, otherwise the least recently used one.
    always_comb begin
        vic = lru_q[in_set];
        if (!bus.miss_vld_i[0]) vic = 1'b0;
        else if (!bus.miss_vld_i[1]) vic = 1'b1;
    end

    assign vic_dirty = bus.miss_vld_i[vic] & bus.miss_dirty_i[vic];

    assign aw_fire = bus.awvalid_o & bus.awready_i;
    assign w_fire  = bus.wvalid_o & bus.wready_i;

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (accept) begin
                    if (vic_dirty) state_d = WB;
                    else if (bus.miss_we_i) state_d = DONE;
                    else state_d = AR;
                end
            end
            WB: begin
                aw_done_d = aw_done_q | aw_fire;
                w_done_d  = w_done_q | w_fire;
                if (aw_done_d & w_done_d) state_d = B_WAIT;
            end
            B_WAIT: if (bus.bvalid_i) state_d = we_q ? DONE : AR;
            AR:     if (bus.arready_i) state_d = R_WAIT;
            R_WAIT: if (bus.rvalid_i) state_d = DONE;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign done      = (state_q == DONE);
    assign rd_err    = ~we_q & (rresp_q != 2'b00);
    assign refill_we = (done & ~rd_err) ? {vic_q, ~vic_q} : 2'b00;
    assign out_dat   = done ? (we_q ? wdat_q : rdata_q) : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            set_q     <= '0;
            tag_q     <= '0;
            is_i_q    <= 1'b0;
            we_q      <= 1'b0;
            wdat_q    <= '0;
            vic_q     <= 1'b0;
            vtag_q    <= '0;
            vdat_q    <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            lru_q     <= '0;
            wb_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            if (accept) begin
                set_q  <= in_set;
                tag_q  <= bus.miss_addr_i[23:8];
                is_i_q <= bus.miss_is_i_i;
                we_q   <= bus.miss_we_i;
                wdat_q <= bus.miss_wdat_i;
                vic_q  <= vic;
                vtag_q <= vic ? bus.miss_tag1_i : bus.miss_tag0_i;
                vdat_q <= vic ? bus.miss_dat1_i : bus.miss_dat0_i;
            end
            if ((state_q == R_WAIT) && bus.rvalid_i) begin
                rdata_q <= bus.rdata_i;
                rresp_q <= bus.rresp_i;
            end
            if ((state_q == B_WAIT) && bus.bvalid_i && (bus.bresp_i != 2'b00))
                wb_err_q <= 1'b1;
            // Refill is written last so it overrides a same-set hit.
            if (bus.hit_valid_i) lru_q[bus.hit_set_i] <= ~bus.hit_way_i;
            if (refill_we != 2'b00) lru_q[set_q] <= ~vic_q;
        end
    end

    assign bus.miss_ready_o   = (state_q == IDLE);
    assign bus.awvalid_o      = (state_q == WB) & ~aw_done_q;
    assign bus.wvalid_o       = (state_q == WB) & ~w_done_q;
    assign bus.awaddr_o       = {8'h00, vtag_q, set_q, 2'b00};
    assign bus.wdata_o        = vdat_q;
    assign bus.bready_o       = (state_q == B_WAIT);
    assign bus.arvalid_o      = (state_q == AR);
    assign bus.araddr_o       = {8'h00, tag_q, set_q, 2'b00};
    assign bus.rready_o       = (state_q == R_WAIT);
    assign bus.refill_we_o    = refill_we;
    assign bus.refill_set_o   = set_q;
    assign bus.refill_tag_o   = tag_q;
    assign bus.refill_dat_o   = out_dat;
    assign bus.refill_dirty_o = done & we_q;
    assign bus.resp_valid_o   = done;
    assign bus.resp_is_i_o    = done & is_i_q;
    assign bus.resp_dat_o     = out_dat;
    assign bus.resp_err_o     = done & rd_err;
    assign bus.wb_err_o       = wb_err_q;
endmodule

// File: tb/tb_l2_refill_ctrl.sv
// Scoreboard bench for l2_refill_ctrl: directed corner cases, then
// randomized misses with randomly delayed bus slaves.
module tb_l2_refill_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    l2_refill_ctrl_if bus ();
    l2_refill_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic        is_i;
        logic [31:0] dat;
        logic        err;
        logic [1:0]  we;
        logic [5:0]  set;
        logic [15:0] tag;
        logic        dirty;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ar_q[$];
    logic [31:0] aw_q[$];
    logic [31:0] w_q[$];
    logic [33:0] r_q[$];
    logic [1:0]  b_q[$];

    bit lru_m[64];
    bit wb_err_m;

    int total = 0;
    int bad = 0;
    bit zero_wait = 1;
    bit hold_r = 0;
    int aw_dly = -1;
    int w_dly = -1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic int pick(input int ov);
        if (ov >= 0) return ov;
        if (zero_wait) return 0;
        return int'($urandom_range(0, 3));
    endfunction

    // Response monitor and idle-quiet checks
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (bus.resp_valid_o) begin
                if (exp_q.size() == 0) chk("resp_unexpected", 1, 0);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("resp_is_i", bus.resp_is_i_o, e.is_i);
                    chk("resp_dat", bus.resp_dat_o, e.dat);
                    chk("resp_err", bus.resp_err_o, e.err);
                    chk("refill_we", bus.refill_we_o, e.we);
                    if (e.we != 2'b00) begin
                        chk("refill_set", bus.refill_set_o, e.set);
                        chk("refill_tag", bus.refill_tag_o, e.tag);
                        chk("refill_dat", bus.refill_dat_o, e.dat);
                        chk("refill_dirty", bus.refill_dirty_o, e.dirty);
                    end
                end
            end else begin
                chk("refill_we_idle", bus.refill_we_o, 0);
            end
            if (bus.miss_ready_o)
                chk("idle_quiet", {bus.arvalid_o, bus.rready_o, bus.awvalid_o,
                    bus.wvalid_o, bus.bready_o, bus.resp_valid_o}, 0);
        end
    end

    initial forever begin
        logic [31:0] a;
        int d;
        @(negedge clk);
        if (rst_n && bus.arvalid_o) begin
            a = bus.araddr_o;
            d = pick(-1);
            repeat (d) @(negedge clk);
            chk("araddr_stable", bus.araddr_o, a);
            if (ar_q.size() == 0) chk("ar_unexpected", 1, 0);
            else chk("araddr", a, ar_q.pop_front());
            bus.arready_i = 1'b1;
            @(negedge clk);
            bus.arready_i = 1'b0;
        end
    end

    initial forever begin
        logic [33:0] r;
        int d;
        @(negedge clk);
        if (rst_n && bus.rready_o && !hold_r) begin
            d = pick(-1);
            repeat (d) @(negedge clk);
            if (r_q.size() == 0) begin
                chk("r_unexpected", 1, 0);
                r = '0;
            end else r = r_q.pop_front();
            bus.rvalid_i = 1'b1;
            bus.rresp_i = r[33:32];
            bus.rdata_i = r[31:0];
            @(negedge clk);
            bus.rvalid_i = 1'b0;
            bus.rdata_i = $urandom;
        end
    end

    initial forever begin
        int d;
        @(negedge clk);
        if (rst_n && bus.awvalid_o) begin
            d = pick(aw_dly);
            repeat (d) @(negedge clk);
            if (aw_q.size() == 0) chk("aw_unexpected", 1, 0);
            else chk("awaddr", bus.awaddr_o, aw_q.pop_front());
            bus.awready_i = 1'b1;
            @(negedge clk);
            bus.awready_i = 1'b0;
        end
    end

    initial forever begin
        int d;
        @(negedge clk);
        if (rst_n && bus.wvalid_o) begin
            d = pick(w_dly);
            repeat (d) @(negedge clk);
            if (w_q.size() == 0) chk("w_unexpected", 1, 0);
            else chk("wdata", bus.wdata_o, w_q.pop_front());
            bus.wready_i = 1'b1;
            @(negedge clk);
            bus.wready_i = 1'b0;
        end
    end

    initial forever begin
        int d;
        @(negedge clk);
        if (rst_n && bus.bready_o) begin
            d = pick(-1);
            repeat (d) @(negedge clk);
            if (b_q.size() == 0) begin
                chk("b_unexpected", 1, 0);
                bus.bresp_i = 2'b00;
            end else bus.bresp_i = b_q.pop_front();
            bus.bvalid_i = 1'b1;
            @(negedge clk);
            bus.bvalid_i = 1'b0;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!bus.miss_ready_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", bus.miss_ready_o, 1);
    endtask

    task automatic do_miss(
        input logic [31:0] addr, input bit is_i, input bit we,
        input logic [31:0] wdat, input logic [1:0] vld,
        input logic [1:0] dirty, input logic [15:0] t0,
        input logic [15:0] t1, input logic [31:0] d0,
        input logic [31:0] d1, input logic [31:0] rdata,
        input logic [1:0] rresp, input logic [1:0] bresp,
        input int hmode, input logic [5:0] hset, input bit hway,
        input int exp_lat);
        logic [5:0]  s;
        logic [15:0] tg;
        bit          v;
        bit          err;
        exp_t        e;
        int          cnt;
        int          lat;
        int          hcyc;
        bit          hit_on;
        bit          hit_used;
        bit          fin;
        logic [5:0]  hs;
        s = addr[7:2];
        tg = addr[23:8];
        wait_ready();
        if (!vld[0]) v = 0;
        else if (!vld[1]) v = 1;
        else v = lru_m[s];
        if (vld[v] && dirty[v]) begin
            aw_q.push_back({8'h00, v ? t1 : t0, s, 2'b00});
            w_q.push_back(v ? d1 : d0);
            b_q.push_back(bresp);
            if (bresp != 2'b00) wb_err_m = 1;
        end
        if (!we) begin
            ar_q.push_back({8'h00, tg, s, 2'b00});
            r_q.push_back({rresp, rdata});
        end
        err = !we && (rresp != 2'b00);
        e.is_i = is_i;
        e.dat = we ? wdat : rdata;
        e.err = err;
        e.we = err ? 2'b00 : (v ? 2'b10 : 2'b01);
        e.set = s;
        e.tag = tg;
        e.dirty = we;
        exp_q.push_back(e);
        bus.miss_addr_i = addr;
        bus.miss_is_i_i = is_i;
        bus.miss_we_i = we;
        bus.miss_wdat_i = wdat;
        bus.miss_vld_i = vld;
        bus.miss_dirty_i = dirty;
        bus.miss_tag0_i = t0;
        bus.miss_tag1_i = t1;
        bus.miss_dat0_i = d0;
        bus.miss_dat1_i = d1;
        bus.miss_valid_i = 1'b1;
        @(posedge clk);
        #1 bus.miss_valid_i = 1'b0;
        hs = (hmode == 2) ? s : hset;
        hcyc = int'($urandom_range(1, 3));
        cnt = 0;
        lat = -1;
        hit_on = 0;
        hit_used = 0;
        fin = 0;
        while (cnt < 300 && !fin) begin
            @(negedge clk);
            cnt++;
            if (hit_on) begin
                bus.hit_valid_i = 1'b0;
                hit_on = 0;
            end
            if (bus.miss_ready_o) fin = 1;
            else begin
                if (bus.resp_valid_o && lat < 0) lat = cnt;
                if (!hit_used && ((hmode == 1 && cnt == hcyc) ||
                    (hmode == 2 && bus.resp_valid_o))) begin
                    bus.hit_valid_i = 1'b1;
                    bus.hit_set_i = hs;
                    bus.hit_way_i = hway;
                    hit_on = 1;
                    hit_used = 1;
                end
            end
        end
        bus.hit_valid_i = 1'b0;
        chk("txn_complete", fin, 1);
        if (exp_lat >= 0) chk("latency", lat, exp_lat);
        chk("wb_err", bus.wb_err_o, wb_err_m);
        if (hit_used) lru_m[hs] = ~hway;
        if (!err) lru_m[s] = ~v;
    endtask

    task automatic rand_miss();
        logic [31:0] a;
        logic [1:0]  rr;
        logic [1:0]  br;
        a = $urandom;
        a[7:2] = 6'($urandom_range(0, 7));
        rr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        br = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        do_miss(a, 1'($urandom), 1'($urandom), $urandom,
                2'($urandom), 2'($urandom), 16'($urandom), 16'($urandom),
                $urandom, $urandom, $urandom, rr, br,
                int'($urandom_range(0, 2)), 6'($urandom_range(0, 7)),
                1'($urandom), -1);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.miss_valid_i = 0; bus.miss_addr_i = 0; bus.miss_is_i_i = 0;
        bus.miss_we_i = 0; bus.miss_wdat_i = 0; bus.miss_vld_i = 0;
        bus.miss_dirty_i = 0; bus.miss_tag0_i = 0; bus.miss_tag1_i = 0;
        bus.miss_dat0_i = 0; bus.miss_dat1_i = 0; bus.hit_valid_i = 0;
        bus.hit_set_i = 0; bus.hit_way_i = 0; bus.arready_i = 0;
        bus.rvalid_i = 0; bus.rdata_i = 0; bus.rresp_i = 0;
        bus.awready_i = 0; bus.wready_i = 0; bus.bvalid_i = 0;
        bus.bresp_i = 0;
        wb_err_m = 0;
        foreach (lru_m[i]) lru_m[i] = 0;
        repeat (3) @(negedge clk);
        chk("rst_ready", bus.miss_ready_o, 1);
        chk("rst_outs", {bus.arvalid_o, bus.rready_o, bus.awvalid_o,
            bus.wvalid_o, bus.bready_o, bus.resp_valid_o,
            bus.refill_we_o, bus.wb_err_o}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        zero_wait = 1;
        // clean read miss, set 5 tag 1234, way 1 invalid
        do_miss(32'h00123414, 1, 0, 0, 2'b01, 2'b00, 16'h1111, 16'h2222,
                32'hA0, 32'hA1, 32'hCAFE0001, 2'b00, 2'b00, 0, 0, 0, 3);
        // dirty victim way 0, awready two cycles ahead of wready
        aw_dly = 0; w_dly = 2;
        do_miss({8'h00, 16'h5678, 6'd7, 2'b00}, 0, 0, 0, 2'b11, 2'b01,
                16'hBEEF, 16'h0F0F, 32'hD0D0D0D0, 32'hD1, 32'h12345678,
                2'b00, 2'b00, 0, 0, 0, 7);
        aw_dly = -1; w_dly = -1;
        // clean write miss
        do_miss({8'h00, 16'h0042, 6'd9, 2'b00}, 0, 1, 32'h77665544,
                2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1);
        // read error response
        do_miss({8'h00, 16'h0099, 6'd10, 2'b00}, 1, 0, 0, 2'b11, 2'b00,
                1, 2, 3, 4, 32'hBAD0BAD0, 2'b10, 2'b00, 0, 0, 0, 3);
        // writeback error, write miss
        do_miss({8'h00, 16'h00AA, 6'd11, 2'b00}, 0, 1, 32'h13579BDF,
                2'b11, 2'b11, 16'h0C0C, 16'h0D0D, 32'h11, 32'h22, 0,
                2'b00, 2'b11, 0, 0, 0, 3);
        // same-cycle hit and refill on one set
        do_miss({8'h00, 16'h0003, 6'd3, 2'b00}, 0, 0, 0, 2'b00, 2'b00,
                0, 0, 0, 0, 32'h33, 2'b00, 2'b00, 2, 0, 0, 3);
        do_miss({8'h00, 16'h0103, 6'd3, 2'b00}, 0, 0, 0, 2'b11, 2'b00,
                5, 6, 7, 8, 32'h34, 2'b00, 2'b00, 0, 0, 0, 3);
        do_miss({8'h00, 16'h0004, 6'd4, 2'b00}, 1, 0, 0, 2'b00, 2'b00,
                0, 0, 0, 0, 32'h44, 2'b00, 2'b00, 2, 0, 1, 3);
        do_miss({8'h00, 16'h0104, 6'd4, 2'b00}, 1, 0, 0, 2'b11, 2'b00,
                9, 10, 11, 12, 32'h45, 2'b00, 2'b00, 0, 0, 0, 3);

        zero_wait = 0;
        repeat (60) rand_miss();

        // reset while in R_WAIT
        zero_wait = 1;
        hold_r = 1;
        wait_ready();
        ar_q.push_back({8'h00, 16'h0202, 6'd2, 2'b00});
        bus.miss_addr_i = {8'h00, 16'h0202, 6'd2, 2'b00};
        bus.miss_we_i = 0;
        bus.miss_vld_i = 2'b00;
        bus.miss_dirty_i = 2'b00;
        bus.miss_valid_i = 1;
        @(posedge clk);
        #1 bus.miss_valid_i = 0;
        begin
            int n = 0;
            while (!bus.rready_o && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        chk("reach_r_wait", bus.rready_o, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", bus.miss_ready_o, 1);
        chk("midrst_outs", {bus.arvalid_o, bus.rready_o, bus.awvalid_o,
            bus.wvalid_o, bus.bready_o, bus.resp_valid_o,
            bus.refill_we_o, bus.wb_err_o}, 0);
        exp_q.delete(); ar_q.delete(); r_q.delete();
        aw_q.delete(); w_q.delete(); b_q.delete();
        foreach (lru_m[i]) lru_m[i] = 0;
        wb_err_m = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hold_r = 0;
        @(negedge clk);

        do_miss({8'h00, 16'h0303, 6'd3, 2'b00}, 0, 0, 0, 2'b11, 2'b00,
                1, 2, 3, 4, 32'h55, 2'b00, 2'b00, 0, 0, 0, 3);
        zero_wait = 0;
        repeat (15) rand_miss();

        wait_ready();
        repeat (4) @(negedge clk);
        chk("scoreboard_empty", exp_q.size() + ar_q.size() + r_q.size() +
            aw_q.size() + w_q.size() + b_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/l2_refill_ctrl.md
L2_REFILL_CTRL -- requirements
Module: l2_refill_ctrl

Interface
REQ-001 SHALL have no parameters; 2 ways, 64 sets, 16-bit tag, one 32-bit word per line.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 miss_valid_i / miss_ready_o  in/out  1/1  miss request handshake.
REQ-005 miss_addr_i  in  32  word address: set = [7:2], tag = [23:8].
REQ-006 miss_is_i_i, miss_we_i, miss_wdat_i  in  1/1/32  requester is i$; d$ write miss; write data.
REQ-007 miss_vld_i, miss_dirty_i  in  2/2  per-way valid and dirty bits of the addressed set.
REQ-008 miss_tag0_i, miss_tag1_i, miss_dat0_i, miss_dat1_i  in  16/16/32/32  per-way stored tag and data.
REQ-009 hit_valid_i, hit_set_i, hit_way_i  in  1/6/1  pipeline hit, used for LRU update.
REQ-010 arvalid_o, arready_i, araddr_o  out/in/out  1/1/32  read address channel.
REQ-011 rvalid_i, rready_o, rdata_i, rresp_i  in/out/in/in  1/1/32/2  read data channel.
REQ-012 awvalid_o, awready_i, awaddr_o  out/in/out  1/1/32  write address channel.
REQ-013 wvalid_o, wready_i, wdata_o  out/in/out  1/1/32  write data channel.
REQ-014 bvalid_i, bready_o, bresp_i  in/out/in  1/1/2  write response channel.
REQ-015 refill_we_o, refill_set_o, refill_tag_o, refill_dat_o, refill_dirty_o  out  2/6/16/32/1  one-hot way write to tag/data RAM.
REQ-016 resp_valid_o, resp_is_i_o, resp_dat_o, resp_err_o  out  1/1/32/1  miss completion to requester.
REQ-017 wb_err_o  out  1  sticky writeback-error flag.

Function
REQ-018 FSM states SHALL be IDLE, WB, B_WAIT, AR, R_WAIT, DONE.
REQ-019 miss_ready_o SHALL be 1 only in IDLE; accept when miss_valid_i & miss_ready_o; capture all miss_* inputs.
REQ-020 Victim: lowest-numbered invalid way; if both valid, the way given by the set's LRU bit.
REQ-021 IDLE on accept: victim valid & dirty -> WB; else write miss -> DONE; else -> AR.
REQ-022 WB: awvalid_o and wvalid_o assert together; awaddr_o = {8'h00, victim tag, set, 2'b00}; wdata_o = victim data; each drops after its own handshake; go to B_WAIT once both done (same cycle allowed).
REQ-023 B_WAIT: bready_o = 1; on bvalid_i -> AR for read miss, DONE for write miss; bresp_i != 0 sets wb_err_o.
REQ-024 AR: arvalid_o = 1, araddr_o = {8'h00, tag, set, 2'b00}, held stable until arready_i; then R_WAIT.
REQ-025 R_WAIT: rready_o = 1; on rvalid_i capture rdata_i and rresp_i; then DONE.
REQ-026 DONE lasts one cycle; resp_valid_o = 1 and resp_is_i_o = captured is_i; next state IDLE.
REQ-027 DONE, read with rresp == 0: refill_we_o one-hot victim; refill_dat_o = resp_dat_o = rdata; refill_dirty_o = 0.
REQ-028 DONE, write miss: refill_we_o one-hot victim; refill_dat_o = resp_dat_o = wdat; refill_dirty_o = 1; no AR.
REQ-029 DONE, read with rresp != 0: refill_we_o = 0; resp_err_o = 1; resp_dat_o = rdata.
REQ-030 refill_set_o and refill_tag_o SHALL equal the captured set and tag whenever refill_we_o != 0.
REQ-031 LRU bit SHALL be set to the not-used way: hit_valid_i sets lru[hit_set_i] = ~hit_way_i; refill sets lru[set] = ~victim.
REQ-032 If a hit and a refill target the same set in the same cycle, the refill update wins.
REQ-033 All handshake outputs SHALL be 0 outside their own states.
REQ-034 Latency, clean read miss, zero-wait bus: accept at T; AR at T+1; R_WAIT at T+2; DONE at T+3; ready again at T+4.

Reset
REQ-035 Reset SHALL force IDLE and clear all LRU bits, wb_err_o, and every valid/we output to 0. Reset mid-transaction abandons the bus transaction.

Verification
REQ-036 Clean read miss, set 5, tag 16'h1234, vld = 2'b01, arready and rvalid immediate -> araddr = 32'h00123414; refill_we = 2'b10 at T+3; resp_valid for 1 cycle.
REQ-037 Dirty victim, both ways valid, lru = 0, dirty = 2'b01 -> AW/W to {tag0, set}; awready 2 cycles before wready; AR only after bvalid.
REQ-038 Write miss into a clean set -> no AR/AW; refill_dirty = 1; refill_dat = wdat; DONE at T+1.
REQ-039 rresp = 2'b10 -> refill_we = 0 and resp_err = 1; bresp = 2'b11 -> wb_err stays 1 until reset.
REQ-040 Same-cycle hit (set 3, way 0) and refill (set 3, way 0) -> lru[3] = 1; then assert rst_n low in R_WAIT -> all outputs 0 and ready in IDLE.
